alu_exec_ctrl: RTL
==================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have parameters: BUS_WIDTH, 8, datapath width; REG_ADDR_BITS, 3, register index width (8 registers); OPCODE_WIDTH, 5, ALU opcode width (2-bit prefix + 3-bit inst).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on posedge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  in  1, in_ready  out  1  operation issue handshake.
REQ-005 SHALL have ports: in_opcode  in  OPCODE_WIDTH; in_rd, in_ra, in_rb  in  REG_ADDR_BITS each; in_use_carry  in  1  (Cin from carry flag).
REQ-006 SHALL have ports: ld_en  in  1, ld_addr  in  REG_ADDR_BITS, ld_data  in  BUS_WIDTH  direct register load.
REQ-007 SHALL have ports: alu_opcode  out  OPCODE_WIDTH, alu_A  out  BUS_WIDTH, alu_B  out  BUS_WIDTH, alu_Cin  out  1  (drive op_decode).
REQ-008 SHALL have ports: alu_Y  in  BUS_WIDTH, alu_Cout  in  1  (combinational result from op_decode).
REQ-009 SHALL have ports: out_valid  out  1, out_data  out  BUS_WIDTH, out_rd  out  REG_ADDR_BITS  writeback report.
REQ-010 SHALL have ports: flag_c, flag_z  out  1 each; dbg_addr  in  REG_ADDR_BITS, dbg_data  out  BUS_WIDTH  (combinational register read).

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, WB; IDLE->EXEC on in_valid&in_ready; EXEC->WB unconditionally; WB->IDLE unconditionally.
REQ-012 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored, no queuing.
REQ-013 On accept edge SHALL register alu_opcode=in_opcode, alu_A=R[in_ra], alu_B=R[in_rb], alu_Cin=in_use_carry&flag_c, and latch in_rd.
REQ-014 On EXEC->WB edge SHALL capture alu_Y into out_data and alu_Cout into a result-carry register.
REQ-015 out_valid SHALL be 1 exactly during the WB cycle; out_data/out_rd hold their values until next WB.
REQ-016 On WB->IDLE edge SHALL write out_data to R[out_rd] and update flag_c=result carry, flag_z=(out_data==0).
REQ-017 R0 SHALL read as 0 always; writes/loads to R0 discarded; flags and out_valid still update for rd=0.
REQ-018 Latency: accept at edge k, out_valid high cycle after edge k+1, register/flag update at edge k+2, in_ready high again after edge k+2; throughput one op per 3 cycles.
REQ-019 ld_en SHALL write ld_data to R[ld_addr] at posedge only in IDLE; ignored in EXEC/WB.
REQ-020 ld_en and accepted in_valid in same IDLE cycle: op SHALL read pre-load register values; load still performed.
REQ-021 dbg_data SHALL equal R[dbg_addr] combinationally; writes visible the cycle after the write edge.
REQ-022 alu_* outputs SHALL hold stable from accept edge through WB.

Reset
REQ-023 rst SHALL asynchronously force state IDLE, R0-R7=0, flag_c=0, flag_z=0, out_valid=0, out_data=0, out_rd=0, alu_opcode=0, alu_A=0, alu_B=0, alu_Cin=0.
REQ-024 rst in EXEC or WB SHALL discard the pending op: no register write, no flag update.
REQ-025 in_ready SHALL be 1 the first cycle after rst deasserts.

Configuration
REQ-026 Macro ALU_EXEC_FLAGS_EN defined: flag_c/flag_z registers and carry-in selection per REQ-013/016.
REQ-027 ALU_EXEC_FLAGS_EN undefined: flag_c=flag_z=0 constant, alu_Cin=0 always, in_use_carry ignored; all other behaviour unchanged.

Verification (bench stub: alu_Y=A+B+Cin, alu_Cout=carry-out)
REQ-028 Load R1=0x05, R2=0x03; issue rd=3, ra=1, rb=2, use_carry=0 -> out_valid 2 cycles after accept, out_data=0x08, out_rd=3, then dbg R3=0x08, flag_z=0, flag_c=0.
REQ-029 R1=0xFF, R2=0x01, rd=4 -> out_data=0x00, flag_c=1, flag_z=1; next op R1+R2 use_carry=1 -> alu_Cin=1, out_data=0x01.
REQ-030 Issue with rd=0 -> out_valid pulses, R0 stays 0x00, flags updated.
REQ-031 in_valid held high continuously -> in_ready 1-of-3 cycles, exactly one accept per 3 cycles, no lost/duplicate ops.
REQ-032 rst asserted during EXEC -> dest register unchanged, out_valid never pulses, all outputs per REQ-023, in_ready=1 after release.
REQ-033 ld_en during EXEC to R5=0xAA -> R5 unchanged; ld_en with accepted op reading R5 in IDLE -> op uses old R5, R5 updated after edge.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: three-phase (IDLE/EXEC/WB) issue controller wrapped around an
// external combinational ALU, with an 8-entry register file (R0 hard-wired 0),
// a direct load port and a combinational debug read port.
// Optional macro ALU_EXEC_FLAGS_EN: enables the carry/zero flag registers and
// carry-in selection; when undefined the flags read 0 and alu_Cin stays 0.
module alu_exec_ctrl #(
  parameter int BUS_WIDTH     = 8,
  parameter int REG_ADDR_BITS = 3,
  parameter int OPCODE_WIDTH  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_WIDTH-1:0]  in_opcode,
  input  logic [REG_ADDR_BITS-1:0] in_rd,
  input  logic [REG_ADDR_BITS-1:0] in_ra,
  input  logic [REG_ADDR_BITS-1:0] in_rb,
  input  logic                     in_use_carry,
  input  logic                     ld_en,
  input  logic [REG_ADDR_BITS-1:0] ld_addr,
  input  logic [BUS_WIDTH-1:0]     ld_data,
  output logic [OPCODE_WIDTH-1:0]  alu_opcode,
  output logic [BUS_WIDTH-1:0]     alu_A,
  output logic [BUS_WIDTH-1:0]     alu_B,
  output logic                     alu_Cin,
  input  logic [BUS_WIDTH-1:0]     alu_Y,
  input  logic                     alu_Cout,
  output logic                     out_valid,
  output logic [BUS_WIDTH-1:0]     out_data,
  output logic [REG_ADDR_BITS-1:0] out_rd,
  output logic                     flag_c,
  output logic                     flag_z,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [BUS_WIDTH-1:0]     dbg_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t                   state;
  logic [BUS_WIDTH-1:0]     regs [NUM_REGS];
  logic [REG_ADDR_BITS-1:0] rd_pend;

  // R0 always reads as zero regardless of storage contents
  function automatic logic [BUS_WIDTH-1:0] reg_read(input logic [REG_ADDR_BITS-1:0] addr);
    return (addr == '0) ? '0 : regs[addr];
  endfunction

  // Ready to issue only while idle
  always_comb in_ready = (state == IDLE);

  // Debug read port
  always_comb dbg_data = reg_read(dbg_addr);

`ifdef ALU_EXEC_FLAGS_EN
  logic res_c;

  // Flag registers: result carry captured in EXEC, committed with the writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_c  <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (state == EXEC) res_c <= alu_Cout;
      if (state == WB) begin
        flag_c <= res_c;
        flag_z <= (out_data == '0);
      end
    end
  end

  // Carry-in selection registered at accept, held through WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         alu_Cin <= 1'b0;
    else if (in_ready && in_valid)   alu_Cin <= in_use_carry & flag_c;
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{in_use_carry, alu_Cout};
  assign flag_c  = 1'b0;
  assign flag_z  = 1'b0;
  assign alu_Cin = 1'b0;
`endif

  // Control FSM, operand/result registers and register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      alu_opcode <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      rd_pend    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_rd     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Operands sample pre-load contents since the load is non-blocking
          if (ld_en && ld_addr != '0) regs[ld_addr] <= ld_data;
          if (in_valid) begin
            alu_opcode <= in_opcode;
            alu_A      <= reg_read(in_ra);
            alu_B      <= reg_read(in_rb);
            rd_pend    <= in_rd;
            state      <= EXEC;
          end
        end
        EXEC: begin
          out_data  <= alu_Y;
          out_rd    <= rd_pend;
          out_valid <= 1'b1;
          state     <= WB;
        end
        WB: begin
          if (out_rd != '0) regs[out_rd] <= out_data;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
